fir_coeff_sample_ctrl: RTL and testbench

Upstream control stage for the 33-tap direct-form FIR datapath. It generates the sample-rate accumulate strobe and the registered 3-bit sample that accompanies it. It also owns the 33 coefficient registers. New coefficient sets are streamed in over a valid/ready handshake into a shadow bank. The shadow bank is copied into the active bank only on a sample boundary, so the filter never computes with a mix of old and new coefficients.

---
 rtl/fir_coeff_sample_ctrl.sv | 143 ++++++++++++++
 tb/tb_fir_coeff_sample_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_sample_ctrl.sv
// Sample-rate strobe generator and double-buffered coefficient bank for the FIR stage.
// Coefficients stream into a shadow bank and are copied to the active bank only on a sample boundary.
module fir_coeff_sample_ctrl #(
  parameter int NUM_TAP    = 33,
  parameter int COEFF_W    = 16,
  parameter int IN_W       = 3,
  parameter int SAMPLE_DIV = 4
) (
  input  logic                       iClk_12M,
  input  logic                       iRst,
  input  logic [IN_W-1:0]            iSampleIn,
  input  logic                       iLoadStart,
  input  logic                       iCoeffValid,
  input  logic [COEFF_W-1:0]         iCoeffData,
  output logic                       oCoeffReady,
  output logic                       oEnAcc,
  output logic [IN_W-1:0]            oFirIn,
  output logic [NUM_TAP*COEFF_W-1:0] oCoeffBus,
  output logic                       oBusy,
  output logic                       oLoadDone,
  output logic                       oLoadErr
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = $clog2(NUM_TAP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TAP - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               en_acc_q, en_acc_d;
  logic [IN_W-1:0]    fir_in_q, fir_in_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [COEFF_W-1:0] shadow_q [NUM_TAP];
  logic [COEFF_W-1:0] shadow_d [NUM_TAP];
  logic [COEFF_W-1:0] active_q [NUM_TAP];
  logic [COEFF_W-1:0] active_d [NUM_TAP];

  logic boundary;
  logic xfer;

  assign boundary = (div_q == DIV_LAST);
  assign xfer     = iCoeffValid && ready_q;

  always_comb begin
    div_d    = boundary ? '0 : div_q + 1'b1;
    en_acc_d = boundary;
    fir_in_d = boundary ? iSampleIn : fir_in_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iLoadStart) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        // A restart beats a coincident transfer; that word is dropped.
        if (iLoadStart) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else if (xfer) begin
          shadow_d[cnt_q] = iCoeffData;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        // Commit lands on the same edge that raises oEnAcc, so the first strobe sees the whole new set.
        if (boundary) begin
          active_d = shadow_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      div_q    <= '0;
      en_acc_q <= 1'b0;
      fir_in_q <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      div_q    <= div_d;
      en_acc_q <= en_acc_d;
      fir_in_q <= fir_in_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    oCoeffBus = '0;
    for (int unsigned k = 0; k < NUM_TAP; k++) begin
      oCoeffBus[k*COEFF_W +: COEFF_W] = active_q[k];
    end
  end

  assign oCoeffReady = ready_q;
  assign oEnAcc      = en_acc_q;
  assign oFirIn      = fir_in_q;
  assign oBusy       = busy_q;
  assign oLoadDone   = done_q;
  assign oLoadErr    = err_q;

endmodule

// File: tb/tb_fir_coeff_sample_ctrl.sv
// Scoreboard bench: a sample/coefficient-set model queues expected strobes; a monitor pops them on oEnAcc.
module tb_fir_coeff_sample_ctrl;

  localparam int NT = 33;
  localparam int CW = 16;
  localparam int IW = 3;
  localparam int SD = 4;

  logic              clk = 1'b0;
  logic              iRst = 1'b1;
  logic [IW-1:0]     iSampleIn = '0;
  logic              iLoadStart = 1'b0;
  logic              iCoeffValid = 1'b0;
  logic [CW-1:0]     iCoeffData = '0;
  logic              oCoeffReady;
  logic              oEnAcc;
  logic [IW-1:0]     oFirIn;
  logic [NT*CW-1:0]  oCoeffBus;
  logic              oBusy;
  logic              oLoadDone;
  logic              oLoadErr;

  fir_coeff_sample_ctrl #(
    .NUM_TAP(NT),
    .COEFF_W(CW),
    .IN_W(IW),
    .SAMPLE_DIV(SD)
  ) dut (
    .iClk_12M(clk),
    .iRst(iRst),
    .iSampleIn(iSampleIn),
    .iLoadStart(iLoadStart),
    .iCoeffValid(iCoeffValid),
    .iCoeffData(iCoeffData),
    .oCoeffReady(oCoeffReady),
    .oEnAcc(oEnAcc),
    .oFirIn(oFirIn),
    .oCoeffBus(oCoeffBus),
    .oBusy(oBusy),
    .oLoadDone(oLoadDone),
    .oLoadErr(oLoadErr)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [NT*CW-1:0] act, input logic [NT*CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [IW-1:0]    fir;
    logic [NT*CW-1:0] bus;
    bit               done;
  } strobe_t;

  strobe_t       sq[$];
  logic [CW-1:0] m_active [NT];
  logic [CW-1:0] m_pend   [NT];
  logic [CW-1:0] m_words[$];
  bit            m_loading = 0, m_committing = 0;
  bit            m_ready = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [IW-1:0] m_fir = '0;
  int unsigned   m_cyc = 0;

  function automatic logic [NT*CW-1:0] pack(input logic [CW-1:0] a [NT]);
    logic [NT*CW-1:0] r;
    r = '0;
    for (int k = 0; k < NT; k++) r[k*CW +: CW] = a[k];
    return r;
  endfunction

  task automatic model_reset();
    foreach (m_active[k]) begin
      m_active[k] = '0;
      m_pend[k]   = '0;
    end
    m_words.delete();
    sq.delete();
    m_loading = 0; m_committing = 0;
    m_ready = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_fir = '0;
    m_cyc = 0;
  endtask

  task automatic model_step();
    bit b;
    b = (m_cyc % SD) == (SD - 1);
    m_done = 0;
    m_err  = 0;
    if (m_committing) begin
      if (b) begin
        m_active = m_pend;
        m_committing = 0;
        m_done = 1;
      end
    end else if (m_loading) begin
      if (iLoadStart) begin
        m_words.delete();
        m_err = 1;
      end else if (iCoeffValid) begin
        m_words.push_back(iCoeffData);
        if (m_words.size() == NT) begin
          foreach (m_pend[k]) m_pend[k] = m_words[k];
          m_words.delete();
          m_loading = 0;
          m_committing = 1;
        end
      end
    end else if (iLoadStart) begin
      m_loading = 1;
      m_words.delete();
    end
    if (b) begin
      m_fir = iSampleIn;
      sq.push_back('{fir: m_fir, bus: pack(m_active), done: m_done});
    end
    m_ready = m_loading;
    m_busy  = m_loading || m_committing;
    m_cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge iRst);
      if (iRst) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  strobe_t mon_s;

  initial begin
    forever begin
      @(negedge clk);
      if (oEnAcc) begin
        if (sq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL strobe_unexpected: got oEnAcc=1 expected no strobe");
        end else begin
          mon_s = sq.pop_front();
          check("strobe_fir", oFirIn, mon_s.fir);
          check_bus("strobe_bus", oCoeffBus, mon_s.bus);
          check("strobe_done", oLoadDone, mon_s.done);
        end
      end else begin
        check("strobe_missing", sq.size(), 0);
        sq.delete();
        check("done_outside_strobe", oLoadDone, 0);
      end
      check("ready", oCoeffReady, m_ready);
      check("busy", oBusy, m_busy);
      check("err", oLoadErr, m_err);
      check("fir_hold", oFirIn, m_fir);
      check_bus("active_bus", oCoeffBus, pack(m_active));
    end
  end

  // ---------------- stimulus ----------------
  int unsigned      errs = 0, dones = 0, xfers = 0;
  bit               snap_on = 0;
  logic [NT*CW-1:0] snap;

  task automatic step();
    @(posedge clk);
    #1;
    if (oLoadErr) errs++;
    if (oLoadDone) dones++;
    if (snap_on && oEnAcc && !oLoadDone) check_bus("bus_stable_during_load", oCoeffBus, snap);
    iSampleIn = 3'($urandom);
  endtask

  task automatic start_load();
    iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
  endtask

  task automatic send_word(input logic [CW-1:0] d, input int gap_pct);
    int  guard;
    bit  acc;
    guard = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      iCoeffValid = 1'b0;
      step();
    end
    iCoeffValid = 1'b1;
    iCoeffData  = d;
    forever begin
      acc = oCoeffReady;
      step();
      guard++;
      if (acc) begin
        xfers++;
        break;
      end
      if (guard > 10) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    iCoeffValid = 1'b0;
    iCoeffData  = 16'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!oLoadDone && n < 3 * SD) begin
      step();
      n++;
    end
    check("done_seen", oLoadDone, 1);
    check("done_with_strobe", oEnAcc, 1);
  endtask

  logic [IW-1:0] t1v [3];
  logic [CW-1:0] w0, wl;
  int unsigned   e0, d0, nw;

  initial begin
    t1v[0] = 3'b100;
    t1v[1] = 3'b011;
    t1v[2] = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enacc", oEnAcc, 0);
    check("rst_firin", oFirIn, 0);
    check_bus("rst_bus", oCoeffBus, '0);
    check("rst_busy", oBusy, 0);
    check("rst_ready", oCoeffReady, 0);
    iRst = 1'b0;

    // strobe period, sample capture and sign preservation
    for (int c = 0; c < 12; c++) begin
      if (c % 4 == 3) iSampleIn = t1v[c / 4];
      step();
      if (c % 4 == 3) begin
        check("t1_strobe", oEnAcc, 1);
        check("t1_firin", oFirIn, t1v[c / 4]);
      end else begin
        check("t1_no_strobe", oEnAcc, 0);
      end
    end
    check_bus("t1_bus_zero", oCoeffBus, '0);

    // back-to-back load 1..33, restart ignored during commit
    start_load();
    check("t2_busy", oBusy, 1);
    xfers = 0;
    for (int i = 0; i < NT; i++) send_word(16'(i + 1), 0);
    check("t2_xfers", xfers, NT);
    check("t2_ready_drop", oCoeffReady, 0);
    if (oBusy && !oLoadDone) begin
      iLoadStart = 1'b1;
      step();
      iLoadStart = 1'b0;
    end
    wait_done();
    check("t2_coeff0", oCoeffBus[15:0], 16'd1);
    check("t2_coeff32", oCoeffBus[527:512], 16'd33);
    step();
    check("t2_idle", oBusy, 0);

    // gapped load with bus snapshot on every strobe
    snap = oCoeffBus;
    snap_on = 1;
    start_load();
    for (int i = 0; i < NT; i++) send_word(16'($urandom), 50);
    wait_done();
    snap_on = 0;

    // aborted load then a full 16'h8000 set
    e0 = errs;
    start_load();
    for (int i = 0; i < 10; i++) send_word(16'($urandom), 20);
    iLoadStart = 1'b1;
    step();
    iLoadStart = 1'b0;
    check("t4_err_pulse", oLoadErr, 1);
    check("t4_still_ready", oCoeffReady, 1);
    for (int i = 0; i < NT; i++) send_word(16'h8000, 20);
    wait_done();
    check("t4_err_count", errs - e0, 1);
    for (int k = 0; k < NT; k++) check("t4_coeff", oCoeffBus[k*CW +: CW], 16'h8000);

    // restart coincident with a transfer discards that word
    start_load();
    for (int i = 0; i < 5; i++) send_word(16'($urandom), 0);
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b1;
    iCoeffData  = 16'hdead;
    step();
    iLoadStart  = 1'b0;
    iCoeffValid = 1'b0;
    check("t6_err_pulse", oLoadErr, 1);
    w0 = 16'($urandom);
    wl = 16'($urandom);
    send_word(w0, 30);
    for (int i = 1; i < NT - 1; i++) send_word(16'($urandom), 30);
    send_word(wl, 30);
    wait_done();
    check("t6_coeff0", oCoeffBus[15:0], w0);
    check("t6_coeff32", oCoeffBus[527:512], wl);

    // asynchronous reset in the middle of a commit
    start_load();
    for (int i = 0; i < NT; i++) send_word(16'($urandom), 0);
    check("t5_in_commit", oBusy, 1);
    #2;
    iRst = 1'b1;
    #1;
    check("t5_enacc", oEnAcc, 0);
    check("t5_firin", oFirIn, 0);
    check_bus("t5_bus", oCoeffBus, '0);
    check("t5_busy", oBusy, 0);
    check("t5_ready", oCoeffReady, 0);
    check("t5_done", oLoadDone, 0);
    check("t5_err", oLoadErr, 0);
    repeat (2) step();
    iRst = 1'b0;
    d0 = dones;
    repeat (3 * SD) step();
    check("t5_no_done", dones, d0);
    check_bus("t5_bus_after", oCoeffBus, '0);

    // randomized loads, some with a random-length abort first
    for (int r = 0; r < 4; r++) begin
      start_load();
      nw = $urandom_range(0, 40);
      if (nw < NT) begin
        for (int i = 0; i < int'(nw); i++) send_word(16'($urandom), 25);
        iLoadStart = 1'b1;
        step();
        iLoadStart = 1'b0;
      end
      for (int i = 0; i < NT; i++) send_word(16'($urandom), 25);
      wait_done();
      repeat ($urandom_range(0, 6)) step();
    end

    repeat (2 * SD) step();
    check("queue_drained", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
